// File: rtl/pool_result_streamer.sv
// Streams the pooling engine's output BRAM as a valid/ready byte stream with last-marking.
// Read issue is credit-limited so the small output FIFO absorbs BRAM latency under backpressure.
module pool_result_streamer #(
    parameter int unsigned OUTSIZE = 9,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned RD_LAT  = 2,
    parameter int unsigned DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm,
    input  logic              pool_done,
    output logic [ADDR_W-1:0] infer_addr,
    input  logic [7:0]        infer_dout,
    output logic              m_valid,
    output logic [7:0]        m_data,
    output logic              m_last,
    input  logic              m_ready,
    output logic              busy,
    output logic              frame_done
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + RD_LAT + 2);

    typedef enum logic [2:0] {
        StIdle,
        StWaitDone,
        StFetch,
        StDrain,
        StFinish
    } state_e;

    state_e state_q, state_d;

    logic [ADDR_W-1:0] issue_idx, out_idx;
    logic [RD_LAT-1:0] vld_sr;
    logic [7:0]        fifo_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  fifo_count, inflight;
    logic              fetch_en, start_frame, issue, push, pop, credit_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (arm) state_d = StWaitDone;
            StWaitDone: if (pool_done) state_d = StFetch;
            StFetch:    if (issue_idx == ADDR_W'(OUTSIZE)) state_d = StDrain;
            StDrain:    if (pop && out_idx == ADDR_W'(OUTSIZE - 1)) state_d = StFinish;
            StFinish:   state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        busy        = (state_q != StIdle);
        frame_done  = (state_q == StFinish);
        fetch_en    = (state_q == StFetch);
        start_frame = (state_q == StWaitDone) && pool_done;
    end

    // Reads still travelling through the engine pipeline hold a FIFO slot in reserve.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < int'(RD_LAT); i++) begin
            inflight = inflight + CNT_W'(vld_sr[i]);
        end
    end

    assign credit_ok = (fifo_count + inflight + CNT_W'(1)) <= CNT_W'(DEPTH);
    assign issue     = fetch_en && (issue_idx < ADDR_W'(OUTSIZE)) && credit_ok;
    assign push      = vld_sr[RD_LAT-1];
    assign m_valid   = (fifo_count != '0);
    assign pop       = m_valid && m_ready;
    assign m_data    = fifo_mem[rd_ptr];
    assign m_last    = m_valid && (out_idx == ADDR_W'(OUTSIZE - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_idx  <= '0;
            out_idx    <= '0;
            infer_addr <= '0;
            vld_sr     <= '0;
        end else begin
            vld_sr <= (vld_sr << 1) | RD_LAT'(issue);
            if (issue) begin
                infer_addr <= issue_idx;
            end
            if (start_frame) begin
                issue_idx <= '0;
                out_idx   <= '0;
            end else begin
                if (issue) issue_idx <= issue_idx + 1'b1;
                if (pop)   out_idx   <= out_idx + 1'b1;
            end
        end
    end

    // Push is unconditional: the issue credit check already guarantees a free slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= infer_dout;
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + CNT_W'(1);
            end else if (pop && !push) begin
                fifo_count <= fifo_count - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pool_result_streamer.sv
// Directed bench for pool_result_streamer with a two-stage output BRAM model
// (engine address register followed by the BRAM read).
module tb_pool_result_streamer;

    logic        clk = 1'b0;
    logic        rst;
    logic        arm;
    logic        pool_done;
    logic [15:0] infer_addr;
    logic [7:0]  infer_dout;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_last;
    logic        m_ready;
    logic        busy;
    logic        frame_done;

    int errors = 0;
    int checks = 0;

    logic [7:0]  bram [16];
    logic [15:0] addr_q;

    pool_result_streamer dut (
        .clk        (clk),
        .rst        (rst),
        .arm        (arm),
        .pool_done  (pool_done),
        .infer_addr (infer_addr),
        .infer_dout (infer_dout),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_last     (m_last),
        .m_ready    (m_ready),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) addr_q <= infer_addr;
    assign infer_dout = (addr_q < 16'd16) ? bram[addr_q[3:0]] : 8'h00;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic pulse_arm();
        @(negedge clk);
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
    endtask

    // mode 0: m_ready always high; mode 1: m_ready toggles 1,0,1,0...
    task automatic stream_frame(input int mode);
        int          k = 0;
        int          cyc = 0;
        logic [7:0]  prev = 8'h00;
        logic        stalled = 1'b0;
        while (k < 9 && cyc < 300) begin
            @(negedge clk);
            m_ready = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
            if (stalled) begin
                check_eq("stall_valid", m_valid, 1);
                check_eq("stall_data", m_data, prev);
            end
            if (m_valid && m_ready) begin
                check_eq("data", m_data, (k + 1) * 10);
                check_eq("last", m_last, k == 8);
                k++;
                stalled = 1'b0;
            end else begin
                stalled = m_valid;
                prev    = m_data;
            end
            cyc++;
        end
        check_eq("byte_count", k, 9);
        @(negedge clk);
        check_eq("frame_done_pulse", frame_done, 1);
        check_eq("busy_finish", busy, 1);
        check_eq("no_extra_valid", m_valid, 0);
        @(negedge clk);
        check_eq("frame_done_clear", frame_done, 0);
        check_eq("busy_idle", busy, 0);
    endtask

    initial begin
        int hs;
        logic [15:0] held;
        for (int i = 0; i < 16; i++) bram[i] = (i < 9) ? 8'((i + 1) * 10) : 8'h00;
        rst       = 1'b1;
        arm       = 1'b0;
        pool_done = 1'b0;
        m_ready   = 1'b0;
        #3;
        check_eq("rst_addr", infer_addr, 0);
        check_eq("rst_valid", m_valid, 0);
        check_eq("rst_data", m_data, 0);
        check_eq("rst_last", m_last, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_fdone", frame_done, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Scenario 1: full-throughput cycle-exact frame
        pool_done = 1'b1;
        m_ready   = 1'b1;
        @(negedge clk);
        arm = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            arm = 1'b0;
            if (c >= 3) check_eq("t1_addr", infer_addr, (c <= 11) ? c - 3 : 8);
            check_eq("t1_valid", m_valid, (c >= 5 && c <= 13));
            if (m_valid) begin
                check_eq("t1_data", m_data, 10 * (c - 4));
                check_eq("t1_last", m_last, c == 13);
            end
            check_eq("t1_fdone", frame_done, c == 14);
            check_eq("t1_busy", busy, c <= 14);
        end

        // Scenario 2: alternating backpressure
        pulse_arm();
        stream_frame(1);

        // Scenario 3: sink stalled from arm; issue stops at FIFO depth
        m_ready = 1'b0;
        pulse_arm();
        repeat (15) @(negedge clk);
        check_eq("t3_addr_hold", infer_addr, 3);
        check_eq("t3_valid", m_valid, 1);
        check_eq("t3_head", m_data, 10);
        check_eq("t3_busy", busy, 1);
        stream_frame(0);

        // Scenario 4: arm before pool_done
        pool_done = 1'b0;
        held      = infer_addr;
        pulse_arm();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check_eq("t4_addr_hold", infer_addr, held);
            check_eq("t4_no_valid", m_valid, 0);
        end
        pool_done = 1'b1;
        stream_frame(0);

        // Scenario 5: reset after the 4th handshake
        m_ready = 1'b1;
        pulse_arm();
        hs = 0;
        for (int c = 0; c < 100 && hs < 4; c++) begin
            @(negedge clk);
            if (m_valid && m_ready) hs++;
        end
        @(negedge clk);
        check_eq("t5_handshakes", hs, 4);
        rst = 1'b1;
        #1;
        check_eq("t5_rst_addr", infer_addr, 0);
        check_eq("t5_rst_valid", m_valid, 0);
        check_eq("t5_rst_data", m_data, 0);
        check_eq("t5_rst_last", m_last, 0);
        check_eq("t5_rst_busy", busy, 0);
        check_eq("t5_rst_fdone", frame_done, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check_eq("t5_quiet_valid", m_valid, 0);
            check_eq("t5_quiet_busy", busy, 0);
        end
        pulse_arm();
        stream_frame(0);

        // Scenario 6: back-to-back frames
        pulse_arm();
        stream_frame(0);
        pulse_arm();
        stream_frame(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
